fetch_ifid: RTL

Instruction-fetch stage with IF/ID pipeline register for the LEGv8 core. Holds the fetch PC and drives the word address of the combinational instruction memory. Captures the returned instruction and its PC into the IF/ID register that feeds decode (register file, sign extension, control). Supports hazard-unit stall, branch redirect/flush, a one-cycle boot bubble and a halt on a branch-to-self instruction.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/ifid_reg.sv | 40 ++++
 rtl/fetch_ifid.sv | 95 +++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the LEGv8 fetch stage and its IF/ID register.
package fetch_pkg;

    typedef enum logic [1:0] {
        F_BOOT,
        F_RUN,
        F_HALTED
    } fetch_state_t;

    // B #0: an unconditional branch to itself, used as the program terminator.
    localparam logic [31:0] HALT_INSTR   = 32'h1400_0000;
    localparam int unsigned INSTR_BYTES  = 4;
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: {instr, pc, valid}. Flush loads a bubble and beats load.
module ifid_reg
    import fetch_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        flush_i,
    input  logic [31:0] instr_i,
    input  logic [63:0] pc_i,
    output logic [31:0] instr_o,
    output logic [63:0] pc_o,
    output logic        valid_o
);

    logic [31:0] instr_q;
    logic [63:0] pc_q;
    logic        valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            instr_q <= BUBBLE_INSTR;
            pc_q    <= 64'h0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= BUBBLE_INSTR;
            pc_q    <= 64'h0;
            valid_q <= 1'b0;
        end else if (en_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            valid_q <= 1'b1;
        end
    end

    assign instr_o = instr_q;
    assign pc_o    = pc_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/fetch_ifid.sv
// Fetch stage: PC register, next-PC mux and BOOT/RUN/HALTED control feeding the IF/ID register.
module fetch_ifid
    import fetch_pkg::*;
#(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int          IMEM_ADDR_W = 6
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   branch_taken,
    input  logic [63:0]            branch_target,
    output logic [IMEM_ADDR_W-1:0] imem_addr,
    input  logic [31:0]            imem_data,
    output logic [63:0]            pc_f,
    output logic [31:0]            instr_d,
    output logic [63:0]            pc_d,
    output logic                   valid_d,
    output logic                   halted
);

    fetch_state_t state_q, state_d;
    logic [63:0]  fpc_q, fpc_d;
    logic         ifid_en;
    logic         ifid_flush;
    logic [63:0]  redirect_pc;

    assign redirect_pc = {branch_target[63:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= F_BOOT;
            fpc_q   <= RESET_PC;
        end else begin
            state_q <= state_d;
            fpc_q   <= fpc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fpc_d      = fpc_q;
        ifid_en    = 1'b0;
        ifid_flush = 1'b0;
        case (state_q)
            F_BOOT: begin
                ifid_flush = 1'b1;
                state_d    = F_RUN;
            end
            F_RUN: begin
                if (branch_taken) begin
                    fpc_d      = redirect_pc;
                    ifid_flush = 1'b1;
                end else if (!stall) begin
                    ifid_en = 1'b1;
                    // The halt word is still passed to decode; only the PC freezes.
                    if (imem_data == HALT_INSTR) begin
                        state_d = F_HALTED;
                    end else begin
                        fpc_d = fpc_q + 64'(INSTR_BYTES);
                    end
                end
            end
            F_HALTED: begin
                if (branch_taken) begin
                    fpc_d      = redirect_pc;
                    ifid_flush = 1'b1;
                    state_d    = F_RUN;
                end else if (!stall) begin
                    ifid_flush = 1'b1;
                end
            end
            default: begin
                state_d = F_BOOT;
            end
        endcase
    end

    ifid_reg u_ifid_reg (
        .clk_i   (clk),
        .rst_i   (reset),
        .en_i    (ifid_en),
        .flush_i (ifid_flush),
        .instr_i (imem_data),
        .pc_i    (fpc_q),
        .instr_o (instr_d),
        .pc_o    (pc_d),
        .valid_o (valid_d)
    );

    assign imem_addr = fpc_q[IMEM_ADDR_W+1:2];
    assign pc_f      = fpc_q;
    assign halted    = (state_q == F_HALTED);

endmodule
